// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Memory handshake between the multi-cycle MIPS control FSM and the shared
//   instruction/data memory.
//
//   Signals
//     mem_req  controller -> memory  access request, held until mem_ack
//     mem_wr   controller -> memory  1 = write access (only meaningful with mem_req)
//     iord     controller -> memory  address select: 0 = PC, 1 = ALUOut
//     mem_ack  memory -> controller  access complete; may rise in the same
//                                    cycle as mem_req
//
//   Modports
//     master   the controller side (drives req/wr/iord, observes ack)
//     slave    the memory side (observes req/wr/iord, drives ack)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_wr;
    logic iord;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_wr,
        output iord,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  iord,
        output mem_ack
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multi-cycle MIPS datapath with one shared
//   instruction/data memory.  Sequences fetch, decode, execute, memory and
//   writeback for lw, sw, add, sub, slt, addi, slti, beq and bne, drives the
//   datapath mux selects and write enables, and counts retired instructions.
//
//   Ports
//     clk         single clock, all state updates on the rising edge
//     rst         synchronous, active-high reset (aborts any access in flight)
//     mem         memory handshake (master side): mem_req, mem_wr, iord, mem_ack
//     opcode      IR[31:26], valid from DECODE onward
//     funct       IR[5:0]
//     zero        ALU zero flag, combinational from the current ALU inputs
//     ir_wr       load IR from memory read data
//     pc_wr       load PC from the pc_src mux
//     pc_src      0 = ALU result (PC+4), 1 = ALUOut (branch target)
//     reg_wr      register-file write enable
//     reg_dst     0 = rt, 1 = rd
//     mem_to_reg  0 = ALUOut, 1 = memory data register
//     alu_src_a   0 = PC, 1 = reg A
//     alu_src_b   00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//     alu_ctrl    010 add, 110 sub, 111 slt
//     illegal     one-cycle pulse in DECODE on an unsupported opcode/funct
//     state_o     current state encoding, for debug
//     instr_cnt   retired-instruction count, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    mem,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic                 pc_src,
    output logic                 reg_wr,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_ctrl,
    output logic                 illegal,
    output logic [3:0]           state_o,
    output logic [CNT_W-1:0]     instr_cnt
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        RTEXEC = 4'd7,
        RTWB   = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        BRANCH = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    logic is_lw;
    logic is_sw;
    logic is_rtype;
    logic is_addi;
    logic is_slti;
    logic is_beq;
    logic is_bne;
    logic is_nop;
    logic r_alu_op;
    logic decode_illegal;

    logic mem_req_c;
    logic mem_wr_c;
    logic iord_c;

    // Instruction class decode straight off the live IR fields.  IR only
    // loads in FETCH, so these are stable for the rest of the instruction.
    always_comb begin
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_rtype = (opcode == OP_RTYPE);
        is_addi  = (opcode == OP_ADDI);
        is_slti  = (opcode == OP_SLTI);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_nop   = is_rtype && (funct == FN_NOP);
        r_alu_op = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
        decode_illegal = !(is_lw || is_sw || is_addi || is_slti || is_beq || is_bne
                           || r_alu_op || is_nop);
    end

    // State register and retired-instruction counter.  An instruction is
    // counted on the edge that leaves its final state; a NOP retires straight
    // out of DECODE, while an illegal instruction returns to FETCH uncounted.
    // Reset wins over everything, so an unacknowledged access is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            instr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_lw || is_sw) begin
                        state <= MEMADR;
                    end else if (r_alu_op) begin
                        state <= RTEXEC;
                    end else if (is_nop) begin
                        state     <= FETCH;
                        instr_cnt <= instr_cnt + CNT_ONE;
                    end else if (is_addi || is_slti) begin
                        state <= IEXEC;
                    end else if (is_beq || is_bne) begin
                        state <= BRANCH;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEMADR: begin
                    if (is_lw) begin
                        state <= MEMRD;
                    end else if (is_sw) begin
                        state <= MEMWR;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEMRD: begin
                    if (mem.mem_ack) begin
                        state <= MEMWB;
                    end
                end
                MEMWB: begin
                    state     <= FETCH;
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
                MEMWR: begin
                    if (mem.mem_ack) begin
                        state     <= FETCH;
                        instr_cnt <= instr_cnt + CNT_ONE;
                    end
                end
                RTEXEC: begin
                    state <= RTWB;
                end
                RTWB: begin
                    state     <= FETCH;
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
                IEXEC: begin
                    state <= IWB;
                end
                IWB: begin
                    state     <= FETCH;
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
                BRANCH: begin
                    state     <= FETCH;
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath controls are a decode of the state register.  The write
    // enables that close a memory access (ir_wr/pc_wr in FETCH) are gated by
    // mem_ack in the same cycle, and the branch PC write is gated by the live
    // zero flag, so these cannot be registered without adding a cycle.
    // IDLE and the unused encodings drive everything to zero, alu_ctrl included.
    always_comb begin
        mem_req_c  = 1'b0;
        mem_wr_c   = 1'b0;
        iord_c     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                alu_ctrl = 3'b000;
            end
            FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                if (mem.mem_ack) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
            end
            DECODE: begin
                // ALUOut captures PC+4 + (imm << 2) here so BRANCH can use it
                alu_src_b = 2'b11;
                illegal   = decode_illegal;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
            end
            MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req_c = 1'b1;
                mem_wr_c  = 1'b1;
                iord_c    = 1'b1;
            end
            RTEXEC: begin
                alu_src_a = 1'b1;
                if (funct == FN_SUB) begin
                    alu_ctrl = ALU_SUB;
                end else if (funct == FN_SLT) begin
                    alu_ctrl = ALU_SLT;
                end
            end
            RTWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (is_slti) begin
                    alu_ctrl = ALU_SLT;
                end
            end
            IWB: begin
                reg_wr = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 1'b1;
                pc_wr     = (is_beq && zero) || (is_bne && !zero);
            end
            default: begin
                alu_ctrl = 3'b000;
            end
        endcase
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_wr  = mem_wr_c;
    assign mem.iord    = iord_c;
    assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for the multi-cycle MIPS control FSM.  A behavioural model
//   expands each instruction into the control word expected on every cycle;
//   a compare process checks the DUT against it on each falling edge, and
//   hand-computed cycle counts, instr_cnt values and reset values pin the
//   model.  A small memory responder acks after a programmable number of
//   wait cycles, separately for instruction (iord=0) and data (iord=1).
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_SLT  = 2;
    localparam int K_LW   = 3;
    localparam int K_SW   = 4;
    localparam int K_ADDI = 5;
    localparam int K_SLTI = 6;
    localparam int K_BEQ  = 7;
    localparam int K_BNE  = 8;
    localparam int K_NOP  = 9;
    localparam int K_ILL  = 10;
    localparam int K_RILL = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        ir_wr;
    logic        pc_wr;
    logic        pc_src;
    logic        reg_wr;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        illegal;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt;

    multicycle_ctrl_if bus ();

    int          fetch_wait;
    int          data_wait;
    int          req_cycles;
    int          write_acks;
    int          check_cnt;
    int          pass_cnt;
    logic [31:0] exp_cnt;
    exp_t        exp_q[$];
    exp_t        cmp_e;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus.master),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .state_o    (state_o),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack once the request has waited the programmed
    // number of cycles for its address source.
    assign bus.mem_ack = bus.mem_req && (req_cycles >= (bus.iord ? data_wait : fetch_wait));

    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ack) begin
            req_cycles <= 0;
        end else begin
            req_cycles <= req_cycles + 1;
        end
        if (!rst && bus.mem_req && bus.mem_wr && bus.mem_ack) begin
            write_acks <= write_acks + 1;
        end
    end

    function automatic ctl_t dut_ctl();
        return {state_o, bus.mem_req, bus.mem_wr, bus.iord, ir_wr, pc_wr, pc_src,
                reg_wr, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt = check_cnt + 1;
        if (act === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flagFail(input string name);
        check_cnt = check_cnt + 1;
        $display("[TB] FAIL %s: got timeout/leftover, expected completion at %0t", name, $time);
    endtask

    // Control word for a given state number with everything idle and the
    // ALU defaulting to add.
    function automatic ctl_t base(input logic [3:0] st);
        ctl_t c;
        c          = '0;
        c.st       = st;
        c.alu_ctrl = 3'b010;
        return c;
    endfunction

    task automatic push(input ctl_t c);
        exp_t e;
        e.ctl = c;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Behavioural model: the full cycle-by-cycle control sequence of one
    // instruction, given its class, the memory wait cycles and the zero flag.
    task automatic model_instr(input int kind, input int fw, input int dw, input bit z);
        ctl_t c;
        bit   retire;
        for (int i = 0; i < fw; i++) begin
            c = base(4'd1); c.mem_req = 1'b1; c.alu_src_b = 2'b01;
            push(c);
        end
        c = base(4'd1); c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_wr = 1'b1; c.pc_wr = 1'b1;
        push(c);
        c = base(4'd2); c.alu_src_b = 2'b11; c.illegal = (kind == K_ILL) || (kind == K_RILL);
        push(c);
        retire = (kind != K_ILL) && (kind != K_RILL);
        if (kind == K_LW || kind == K_SW) begin
            c = base(4'd3); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            push(c);
            for (int i = 0; i <= dw; i++) begin
                c = base(kind == K_LW ? 4'd4 : 4'd6);
                c.mem_req = 1'b1; c.iord = 1'b1; c.mem_wr = (kind == K_SW);
                push(c);
            end
            if (kind == K_LW) begin
                c = base(4'd5); c.reg_wr = 1'b1; c.mem_to_reg = 1'b1;
                push(c);
            end
        end else if (kind == K_ADD || kind == K_SUB || kind == K_SLT) begin
            c = base(4'd7); c.alu_src_a = 1'b1;
            c.alu_ctrl = (kind == K_SUB) ? 3'b110 : (kind == K_SLT) ? 3'b111 : 3'b010;
            push(c);
            c = base(4'd8); c.reg_wr = 1'b1; c.reg_dst = 1'b1;
            push(c);
        end else if (kind == K_ADDI || kind == K_SLTI) begin
            c = base(4'd9); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            c.alu_ctrl = (kind == K_SLTI) ? 3'b111 : 3'b010;
            push(c);
            c = base(4'd10); c.reg_wr = 1'b1;
            push(c);
        end else if (kind == K_BEQ || kind == K_BNE) begin
            c = base(4'd11); c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 1'b1;
            c.pc_wr = (kind == K_BEQ) ? z : !z;
            push(c);
        end
        if (retire) begin
            exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    // Compare process: one model record per cycle while the model has one.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            checkOutput($sformatf("ctl_st%0d", cmp_e.ctl.st), 64'(dut_ctl()), 64'(cmp_e.ctl));
            checkOutput($sformatf("cnt_st%0d", cmp_e.ctl.st), 64'(instr_cnt), 64'(cmp_e.cnt));
        end
    end

    task automatic setInstr(input int kind, input bit z);
        case (kind)
            K_ADD:   begin opcode = 6'h00; funct = 6'h20; end
            K_SUB:   begin opcode = 6'h00; funct = 6'h22; end
            K_SLT:   begin opcode = 6'h00; funct = 6'h2A; end
            K_LW:    begin opcode = 6'h23; funct = 6'h15; end
            K_SW:    begin opcode = 6'h2B; funct = 6'h2A; end
            K_ADDI:  begin opcode = 6'h08; funct = 6'h22; end
            K_SLTI:  begin opcode = 6'h0A; funct = 6'h20; end
            K_BEQ:   begin opcode = 6'h04; funct = 6'h00; end
            K_BNE:   begin opcode = 6'h05; funct = 6'h00; end
            K_NOP:   begin opcode = 6'h00; funct = 6'h00; end
            K_ILL:   begin opcode = 6'h3F; funct = 6'h20; end
            default: begin opcode = 6'h00; funct = 6'h08; end
        endcase
        zero = z;
    endtask

    // Called #1 after the edge that entered FETCH.  Runs one instruction,
    // measures FETCH-to-FETCH cycles on the DUT, then checks the literals.
    task automatic applyStimulus(input int kind, input bit z, input int fw, input int dw,
                                 input int exp_cycles, input logic [31:0] exp_count);
        int n;
        setInstr(kind, z);
        fetch_wait = fw;
        data_wait  = dw;
        model_instr(kind, fw, dw, z);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (state_o == 4'd1 && n < 60);
        while (state_o != 4'd1 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 60) begin
            flagFail($sformatf("timeout_kind%0d", kind));
        end
        checkOutput($sformatf("cycles_kind%0d", kind), 64'(n), 64'(exp_cycles));
        if (exp_q.size() != 0) begin
            flagFail($sformatf("model_leftover_kind%0d", kind));
            exp_q.delete();
        end
        checkOutput($sformatf("instr_cnt_kind%0d", kind), 64'(instr_cnt), 64'(exp_count));
    endtask

    initial begin
        check_cnt  = 0;
        pass_cnt   = 0;
        exp_cnt    = 32'd0;
        write_acks = 0;
        fetch_wait = 0;
        data_wait  = 0;
        rst        = 1'b1;
        setInstr(K_NOP, 1'b0);

        // Reset held three edges: everything zero, then FETCH one cycle after release
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 64'(dut_ctl()), 64'd0);
        checkOutput("reset_cnt", 64'(instr_cnt), 64'd0);
        rst = 1'b0;
        push('0);
        @(posedge clk); #1;
        checkOutput("fetch_after_reset", 64'(state_o), 64'd1);

        applyStimulus(K_ADD,  1'b0, 0, 0, 4, 32'd1);
        applyStimulus(K_SUB,  1'b0, 0, 0, 4, 32'd2);
        applyStimulus(K_SLT,  1'b0, 0, 0, 4, 32'd3);
        applyStimulus(K_LW,   1'b0, 0, 3, 8, 32'd4);
        applyStimulus(K_LW,   1'b0, 2, 0, 7, 32'd5);
        applyStimulus(K_SW,   1'b0, 0, 0, 4, 32'd6);
        applyStimulus(K_SW,   1'b0, 0, 1, 5, 32'd7);
        applyStimulus(K_ADDI, 1'b0, 0, 0, 4, 32'd8);
        applyStimulus(K_SLTI, 1'b0, 0, 0, 4, 32'd9);
        applyStimulus(K_BEQ,  1'b1, 0, 0, 3, 32'd10);
        applyStimulus(K_BEQ,  1'b0, 0, 0, 3, 32'd11);
        applyStimulus(K_BNE,  1'b1, 0, 0, 3, 32'd12);
        applyStimulus(K_BNE,  1'b0, 0, 0, 3, 32'd13);
        applyStimulus(K_ILL,  1'b0, 0, 0, 2, 32'd13);
        applyStimulus(K_RILL, 1'b0, 0, 0, 2, 32'd13);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(K_NOP, 1'b0, 0, 0, 2, 32'd13 + 32'(i));
        end
        checkOutput("write_acks_before_abort", 64'(write_acks), 64'd2);

        // sw whose write is never acked; reset lands in the second MEMWR cycle
        setInstr(K_SW, 1'b0);
        fetch_wait = 0;
        data_wait  = 1000;
        model_instr(K_SW, 0, 1000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("in_memwr", 64'(state_o), 64'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        exp_cnt = 32'd0;
        checkOutput("abort_state", 64'(state_o), 64'd0);
        checkOutput("abort_mem_req", 64'(bus.mem_req), 64'd0);
        checkOutput("abort_cnt", 64'(instr_cnt), 64'd0);
        push('0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("fetch_after_abort", 64'(state_o), 64'd1);
        checkOutput("write_acks_after_abort", 64'(write_acks), 64'd2);
        applyStimulus(K_ADD, 1'b0, 0, 0, 4, 32'd1);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
